// File: rtl/gtx_rx_word_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : gtx_rx_word_aligner
//  Purpose  : Finds the bit offset of a repeating sync word in raw GT RX
//             parallel data, confirms it repeats every FRAME_WORDS words,
//             then emits realigned words with frame-start and lock status.
//  Revision : 1.0  initial release
// ============================================================================
module gtx_rx_word_aligner #(
   parameter int                    DATA_WIDTH   = 20,
   parameter logic [DATA_WIDTH-1:0] SYNC_PATTERN = 20'h5A3C7,
   parameter logic [DATA_WIDTH-1:0] SYNC_MASK    = 20'hFFFFF,
   parameter int                    FRAME_WORDS  = 16,
   parameter int                    LOCK_COUNT   = 4,
   parameter int                    UNLOCK_COUNT = 3,
   localparam int                   OFS_W        = $clog2(DATA_WIDTH)
) (
   input  logic                  data_clk,
   input  logic                  rx_system_reset,
   input  logic [DATA_WIDTH-1:0] raw_data_in,
   input  logic                  force_search,
   output logic [DATA_WIDTH-1:0] aligned_data_out,
   output logic                  aligned_valid_out,
   output logic                  sync_flag_out,
   output logic                  locked_out,
   output logic [OFS_W-1:0]      bit_offset_out,
   output logic                  sync_error_out,
   output logic [15:0]           lock_loss_count_out
);

   localparam int POS_W  = $clog2(FRAME_WORDS);
   localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] prev_q;
   logic [POS_W-1:0]      pos_q, pos_d;
   logic [HIT_W-1:0]      hit_cnt_q, hit_cnt_d;
   logic [MISS_W-1:0]     miss_cnt_q, miss_cnt_d;
   logic [OFS_W-1:0]      offset_q, offset_d;
   logic [DATA_WIDTH-1:0] aligned_q, aligned_d;
   logic                  locked_q, locked_d;
   logic                  sync_flag_q, sync_flag_d;
   logic                  sync_err_q, sync_err_d;
   logic [15:0]           loss_q, loss_d;

   // Two-word window: previous word in the low half, current word on top,
   // so bit 0 of the window is the earliest received bit.
   logic [2*DATA_WIDTH-1:0] cat;
   logic [OFS_W:0]          offset_ext;
   logic [DATA_WIDTH-1:0]   match;
   logic                    any_match;
   logic [OFS_W-1:0]        first_ofs;
   logic                    match_cur;
   logic                    check_cycle;
   logic [HIT_W-1:0]        hit_inc;
   logic [MISS_W-1:0]       miss_inc;

   assign cat        = {raw_data_in, prev_q};
   assign offset_ext = {1'b0, offset_q};
   assign match_cur  = match[offset_q];
   assign hit_inc    = hit_cnt_q + HIT_W'(1);
   assign miss_inc   = miss_cnt_q + MISS_W'(1);
   assign check_cycle = (state_q != ST_SEARCH) && (pos_q == '0);

   generate
      for (genvar o = 0; o < DATA_WIDTH; o++) begin : g_match
         assign match[o] = ((cat[o +: DATA_WIDTH] ^ SYNC_PATTERN) & SYNC_MASK) == '0;
      end
   endgenerate

   // Priority pick of the lowest matching offset in the window.
   always_comb begin
      any_match = 1'b0;
      first_ofs = '0;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         if (match[i]) begin
            any_match = 1'b1;
            first_ofs = OFS_W'(i);
         end
      end
   end

   // Next-state, counters and registered-output values.
   always_comb begin
      state_d     = state_q;
      pos_d       = (pos_q == POS_W'(FRAME_WORDS - 1)) ? '0 : pos_q + POS_W'(1);
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      offset_d    = offset_q;
      loss_d      = loss_q;
      sync_flag_d = 1'b0;
      sync_err_d  = 1'b0;
      aligned_d   = cat[offset_ext +: DATA_WIDTH];

      case (state_q)
         ST_SEARCH: begin
            if (any_match) begin
               offset_d  = first_ofs;
               hit_cnt_d = '0;
               pos_d     = POS_W'(1);
               state_d   = ST_VERIFY;
            end
         end
         ST_VERIFY: begin
            if (check_cycle) begin
               if (match_cur) begin
                  pos_d     = POS_W'(1);
                  hit_cnt_d = hit_inc;
                  if (hit_inc == HIT_W'(LOCK_COUNT)) begin
                     state_d    = ST_LOCKED;
                     miss_cnt_d = '0;
                  end
               end else begin
                  state_d = ST_SEARCH;
               end
            end
         end
         ST_LOCKED: begin
            if (check_cycle) begin
               if (match_cur) begin
                  pos_d       = POS_W'(1);
                  miss_cnt_d  = '0;
                  sync_flag_d = 1'b1;
               end else begin
                  // pos keeps free-running so the expected sync slot survives misses
                  sync_err_d = 1'b1;
                  miss_cnt_d = miss_inc;
                  if (miss_inc == MISS_W'(UNLOCK_COUNT)) begin
                     state_d = ST_SEARCH;
                     loss_d  = (loss_q == 16'hFFFF) ? loss_q : loss_q + 16'd1;
                  end
               end
            end
         end
         default: state_d = ST_SEARCH;
      endcase

      // An external resync request overrides whatever the FSM decided.
      if (force_search) begin
         state_d     = ST_SEARCH;
         hit_cnt_d   = '0;
         miss_cnt_d  = '0;
         offset_d    = offset_q;
         loss_d      = loss_q;
         sync_flag_d = 1'b0;
         sync_err_d  = 1'b0;
      end

      locked_d = (state_d == ST_LOCKED);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge data_clk or posedge rx_system_reset) begin
      if (rx_system_reset) begin
         state_q     <= ST_SEARCH;
         prev_q      <= '0;
         pos_q       <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         offset_q    <= '0;
         aligned_q   <= '0;
         locked_q    <= 1'b0;
         sync_flag_q <= 1'b0;
         sync_err_q  <= 1'b0;
         loss_q      <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= raw_data_in;
         pos_q       <= pos_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         offset_q    <= offset_d;
         aligned_q   <= aligned_d;
         locked_q    <= locked_d;
         sync_flag_q <= sync_flag_d;
         sync_err_q  <= sync_err_d;
         loss_q      <= loss_d;
      end
   end

   assign aligned_data_out    = aligned_q;
   assign aligned_valid_out   = locked_q;
   assign locked_out          = locked_q;
   assign sync_flag_out       = sync_flag_q;
   assign bit_offset_out      = offset_q;
   assign sync_error_out      = sync_err_q;
   assign lock_loss_count_out = loss_q;

endmodule
`default_nettype wire

// File: tb/tb_gtx_rx_word_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gtx_rx_word_aligner
//  Purpose  : Self-checking bench for gtx_rx_word_aligner. Builds a serial
//             bit stream with sync words at a chosen bit offset, slices it
//             into raw words and scoreboards the realigned output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gtx_rx_word_aligner;

   localparam int          W    = 20;
   localparam int          FW   = 16;
   localparam logic [W-1:0] PAT = 20'h5A3C7;
   localparam int          MAXW = 340;
   localparam int          MAXB = MAXW * W;

   logic          data_clk = 1'b0;
   logic          rx_system_reset;
   logic [W-1:0]  raw_data_in;
   logic          force_search;
   logic [W-1:0]  aligned_data_out;
   logic          aligned_valid_out;
   logic          sync_flag_out;
   logic          locked_out;
   logic [4:0]    bit_offset_out;
   logic          sync_error_out;
   logic [15:0]   lock_loss_count_out;

   // Second instance compares only the low 10 bits, so two matches can
   // coexist in one window without overlapping.
   logic [W-1:0]  m_raw;
   logic          m_force;
   logic [W-1:0]  m_data;
   logic          m_valid, m_flag, m_locked, m_err;
   logic [4:0]    m_ofs;
   logic [15:0]   m_loss;

   always #5 data_clk = ~data_clk;

   gtx_rx_word_aligner u_dut (
      .data_clk            (data_clk),
      .rx_system_reset     (rx_system_reset),
      .raw_data_in         (raw_data_in),
      .force_search        (force_search),
      .aligned_data_out    (aligned_data_out),
      .aligned_valid_out   (aligned_valid_out),
      .sync_flag_out       (sync_flag_out),
      .locked_out          (locked_out),
      .bit_offset_out      (bit_offset_out),
      .sync_error_out      (sync_error_out),
      .lock_loss_count_out (lock_loss_count_out)
   );

   gtx_rx_word_aligner #(
      .DATA_WIDTH   (20),
      .SYNC_PATTERN (20'h5A3C7),
      .SYNC_MASK    (20'h003FF)
   ) u_dut_mask (
      .data_clk            (data_clk),
      .rx_system_reset     (rx_system_reset),
      .raw_data_in         (m_raw),
      .force_search        (m_force),
      .aligned_data_out    (m_data),
      .aligned_valid_out   (m_valid),
      .sync_flag_out       (m_flag),
      .locked_out          (m_locked),
      .bit_offset_out      (m_ofs),
      .sync_error_out      (m_err),
      .lock_loss_count_out (m_loss)
   );

   int    checks = 0;
   int    errors = 0;
   string cur_test = "reset";

   bit          sbits [0:MAXB-1];
   bit          prot  [0:MAXB-1];
   bit          smark [0:MAXB-1];
   bit          locked_h [0:MAXW+1];
   logic [4:0]  ofs_h    [0:MAXW+1];
   logic [15:0] loss_h   [0:MAXW+1];
   int          nflag, nerr;
   logic [W-1:0] exp_q [$];
   bit           esync_q [$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s/%s got=%0h exp=%0h", cur_test, tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] get_win(input int p);
      logic [W-1:0] v;
      for (int i = 0; i < W; i++) v[i] = sbits[p + i];
      return v;
   endfunction

   task automatic put_pat(input int p, input bit mark);
      for (int i = 0; i < W; i++) begin
         sbits[p + i] = PAT[i];
         prot[p + i]  = 1'b1;
      end
      smark[p] = mark;
   endtask

   // Random stream with syncs at (first_word + j*FW)*W + off; slots flagged
   // in bad_mask stay random. Accidental pattern copies are broken up.
   task automatic build(input int off, input int first_word, input int nslots,
                        input int bad_mask, input int alias_pos);
      bit changed;
      int guard;
      for (int p = 0; p < MAXB; p++) begin
         sbits[p] = 1'($urandom);
         prot[p]  = 1'b0;
         smark[p] = 1'b0;
      end
      for (int j = 0; j < nslots; j++)
         if (!bad_mask[j]) put_pat((first_word + j * FW) * W + off, 1'b1);
      if (alias_pos >= 0) put_pat(alias_pos, 1'b0);
      guard = 0;
      do begin
         changed = 1'b0;
         for (int p = 0; p <= MAXB - W; p++) begin
            if (!smark[p] && p != alias_pos && get_win(p) == PAT) begin
               for (int i = 0; i < W; i++) begin
                  if (!prot[p + i]) begin
                     sbits[p + i] = ~sbits[p + i];
                     changed = 1'b1;
                     break;
                  end
               end
            end
         end
         guard++;
      end while (changed && guard < 20);
   endtask

   task automatic do_reset();
      rx_system_reset = 1'b1;
      raw_data_in     = '0;
      force_search    = 1'b0;
      m_raw           = '0;
      repeat (2) @(posedge data_clk);
      @(negedge data_clk);
      rx_system_reset = 1'b0;
   endtask

   // Drives raw words k = 0..nwords-1; history index k+1 holds the outputs
   // seen after the edge that consumed word k.
   task automatic run_stream(input int nwords, input int exp_off, input int force_at);
      logic [W-1:0] e;
      bit           es;
      nflag = 0;
      nerr  = 0;
      for (int t = 0; t <= MAXW + 1; t++) begin
         locked_h[t] = 1'b0;
         ofs_h[t]    = '0;
         loss_h[t]   = '0;
      end
      for (int k = 0; k < nwords; k++) begin
         raw_data_in  = get_win(k * W);
         force_search = (k == force_at);
         if (k >= 1) begin
            e  = get_win((k - 1) * W + exp_off);
            es = smark[(k - 1) * W + exp_off];
         end else begin
            e  = '0;
            es = 1'b0;
         end
         exp_q.push_back(e);
         esync_q.push_back(es);
         @(posedge data_clk);
         #1;
         e  = exp_q.pop_front();
         es = esync_q.pop_front();
         locked_h[k + 1] = locked_out;
         ofs_h[k + 1]    = bit_offset_out;
         loss_h[k + 1]   = lock_loss_count_out;
         if (aligned_valid_out) check_eq("data", aligned_data_out, e);
         if (sync_flag_out) begin
            nflag++;
            check_eq("flag_word", aligned_data_out, PAT);
            check_eq("flag_slot", es, 1);
         end
         if (sync_error_out) nerr++;
      end
      force_search = 1'b0;
   endtask

   initial begin
      rx_system_reset = 1'b1;
      raw_data_in     = '0;
      force_search    = 1'b0;
      m_raw           = '0;
      m_force         = 1'b0;
      repeat (2) @(posedge data_clk);
      #1;
      check_eq("rst_locked", locked_out, 0);
      check_eq("rst_valid", aligned_valid_out, 0);
      check_eq("rst_flag", sync_flag_out, 0);
      check_eq("rst_err", sync_error_out, 0);
      check_eq("rst_loss", lock_loss_count_out, 0);
      check_eq("rst_ofs", bit_offset_out, 0);
      check_eq("rst_data", aligned_data_out, 0);

      // Offset 7: lock, single miss, triple miss with relock.
      cur_test = "ofs7";
      build(7, 2, 20, (1 << 8) | (1 << 11) | (1 << 12) | (1 << 13), -1);
      do_reset();
      run_stream(312, 7, -1);
      check_eq("pre_lock", locked_h[67], 0);
      check_eq("lock_c65", locked_h[68], 1);
      check_eq("lock_ofs", ofs_h[68], 7);
      check_eq("hold_after_1miss", locked_h[140], 1);
      check_eq("held_before_3rd", locked_h[211], 1);
      check_eq("drop_after_3rd", locked_h[212], 0);
      check_eq("loss_before", loss_h[211], 0);
      check_eq("loss_after", loss_h[212], 1);
      check_eq("relock_pre", locked_h[291], 0);
      check_eq("relock", locked_h[292], 1);
      check_eq("err_pulses", nerr, 4);
      check_eq("flag_count", nflag, 6);

      // Asynchronous reset while locked clears everything immediately.
      cur_test = "rst_mid";
      check_eq("pre_rst_lock", locked_out, 1);
      #3;
      rx_system_reset = 1'b1;
      #1;
      check_eq("locked", locked_out, 0);
      check_eq("valid", aligned_valid_out, 0);
      check_eq("data", aligned_data_out, 0);
      check_eq("ofs", bit_offset_out, 0);
      check_eq("loss", lock_loss_count_out, 0);
      #2;
      rx_system_reset = 1'b0;

      // Edge offsets 0 and 19.
      cur_test = "ofs0";
      build(0, 2, 6, 0, -1);
      do_reset();
      run_stream(90, 0, -1);
      check_eq("pre_lock", locked_h[67], 0);
      check_eq("lock", locked_h[68], 1);
      check_eq("ofs", ofs_h[68], 0);
      check_eq("flags", nflag, 1);

      cur_test = "ofs19";
      build(19, 2, 6, 0, -1);
      do_reset();
      run_stream(90, 19, -1);
      check_eq("pre_lock", locked_h[67], 0);
      check_eq("lock", locked_h[68], 1);
      check_eq("ofs", ofs_h[68], 19);
      check_eq("flags", nflag, 1);

      // Alias at offset 3 (bit 23) ahead of true syncs at offset 11.
      cur_test = "alias";
      build(11, 20, 6, 0, W + 3);
      do_reset();
      run_stream(106, 11, -1);
      check_eq("alias_ofs", ofs_h[3], 3);
      check_eq("alias_unlocked", locked_h[3], 0);
      check_eq("pre_lock", locked_h[85], 0);
      check_eq("lock", locked_h[86], 1);
      check_eq("ofs", ofs_h[86], 11);
      check_eq("loss", loss_h[86], 0);
      check_eq("err_pulses", nerr, 0);

      // force_search coincides with the third miss.
      cur_test = "force";
      build(5, 2, 10, (1 << 6) | (1 << 7) | (1 << 8), -1);
      do_reset();
      run_stream(150, 5, 131);
      check_eq("lock", locked_h[68], 1);
      check_eq("held_before", locked_h[131], 1);
      check_eq("dropped", locked_h[132], 0);
      check_eq("loss_132", loss_h[132], 0);
      check_eq("loss_end", loss_h[150], 0);

      // Matches at offsets 2 and 12 of one window: lowest wins.
      cur_test = "dual";
      do_reset();
      m_raw = 20'hC7F1C;
      @(posedge data_clk);
      #1;
      check_eq("first_ofs", m_ofs, 0);
      m_raw = 20'h00003;
      @(posedge data_clk);
      #1;
      check_eq("pick_low", m_ofs, 2);
      check_eq("data_ofs0", m_data, 20'hC7F1C);
      check_eq("not_locked", {m_locked, m_valid, m_flag, m_err}, 0);
      check_eq("loss", m_loss, 0);
      m_raw = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
